uart_rx_frame_assembler: RTL and testbench

- Successor to the single-buffer UART RX frame collector.
- Packs DEPTH received words of WIDTH bits into one parallel frame.
- Uses two ping-pong banks, so the next frame can be collected while the current one waits for the consumer.
- Adds a valid/ready output handshake, overflow detection, resync, and an optional idle timeout.
- Sits between the UART RX byte deserialiser and the frame consumers in the DSP/FFT path.

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_idle_timer.sv | 41 ++++
 rtl/uart_rx_frame_assembler.sv | 156 +++++++++++++++
 tb/tb_uart_rx_frame_assembler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and helpers for the UART RX frame assembler slice.
//   ptr_w(depth) : width of a write index able to address 0..depth-1
//   bank_sel_t   : which of the two ping-pong banks is selected
// ---------------------------------------------------------------------------
package uart_frame_pkg;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_t;

    // A one-entry index still needs one bit of storage.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// ---------------------------------------------------------------------------
// uart_idle_timer
// Counts cycles while enabled; o_expire is asserted combinationally on the
// cycle the count sits at TIMEOUT_CYCLES-1, and the counter wraps to 0.
// A clear has priority over counting and expiry.
// Ports:
//   clk      : clock, rising edge
//   arstn    : asynchronous active-low reset
//   i_clear  : restart the count at 0
//   i_enable : count this cycle
//   o_expire : the idle interval ends this cycle
// ---------------------------------------------------------------------------
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic arstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          w_at_end;

    assign w_at_end = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign o_expire = i_enable & ~i_clear & w_at_end;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_cnt <= '0;
        end else if (i_clear || o_expire) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_assembler
// Packs DEPTH received WIDTH-bit words into one parallel frame using two
// ping-pong banks, so a new frame can be collected while the previous one
// waits for the consumer.
// Optional feature macro: UART_FRAME_TIMEOUT_EN (idle timeout of a partial
// frame). Without it no counter exists and timeout_o is tied low.
// Ports:
//   clk, arstn     : clock (rising edge), asynchronous active-low reset
//   push           : write_data holds a received word this cycle
//   write_data     : received word
//   resync_i       : drop the partial frame, next word starts a frame
//   valid_o/ready_i: output frame handshake
//   read_data      : frame, word [0] in bits [WIDTH-1:0] is the oldest
//   fill_o         : words held in the frame under assembly
//   ovf_o/clr_ovf_i: sticky overflow flag and its clear
//   timeout_o      : one-cycle pulse when a partial frame is dropped idle
//
// Handshake: a frame transfers on every rising edge where valid_o and
// ready_i are both high. While valid_o=1 and ready_i=0, read_data holds.
// ready_i without valid_o does nothing; valid_o never depends on ready_i.
// ---------------------------------------------------------------------------
module uart_rx_frame_assembler
    import uart_frame_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           push,
    input  logic [WIDTH-1:0]               write_data,
    input  logic                           resync_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [DEPTH*WIDTH-1:0]         read_data,
    output logic [$clog2(DEPTH+1)-1:0]     fill_o,
    output logic                           ovf_o,
    input  logic                           clr_ovf_i,
    output logic                           timeout_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);

    logic [PW-1:0]    r_wr_idx;
    bank_sel_t        r_wr_bank;
    bank_sel_t        r_rd_bank;
    logic [1:0]       r_full;
    logic             r_ovf;
    logic [WIDTH-1:0] r_mem [2][DEPTH];

    logic             w_wr_sel;
    logic             w_rd_sel;
    logic             w_accept;
    logic             w_drop;
    logic             w_last;
    logic             w_complete;
    logic             w_read;
    logic             w_expire;
    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_wr_idx_nxt;

    assign w_wr_sel = (r_wr_bank == BANK1);
    assign w_rd_sel = (r_rd_bank == BANK1);

    always_comb begin
        w_accept     = push & ~r_full[w_wr_sel];
        w_drop       = push & r_full[w_wr_sel];
        // A resync in the same cycle as a push makes that word index 0.
        w_wr_ptr     = resync_i ? '0 : r_wr_idx;
        w_last       = (w_wr_ptr == PW'(DEPTH - 1));
        w_complete   = w_accept & w_last;
        w_read       = r_full[w_rd_sel] & ready_i;
        w_wr_idx_nxt = r_wr_idx;
        if (w_accept) begin
            w_wr_idx_nxt = w_last ? '0 : w_wr_ptr + PW'(1);
        end else if (resync_i || w_expire) begin
            w_wr_idx_nxt = '0;
        end
    end

    // Completion and read always target different banks: a bank is only
    // written while not full, and only read while full.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_wr_idx  <= '0;
            r_wr_bank <= BANK0;
            r_rd_bank <= BANK0;
            r_full    <= 2'b00;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_idx <= w_wr_idx_nxt;
            if (w_complete) begin
                r_full[w_wr_sel] <= 1'b1;
                r_wr_bank        <= (r_wr_bank == BANK0) ? BANK1 : BANK0;
            end
            if (w_read) begin
                r_full[w_rd_sel] <= 1'b0;
                r_rd_bank        <= (r_rd_bank == BANK0) ? BANK1 : BANK0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Bank storage carries no reset; its content only matters while full.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_wr_sel][w_wr_ptr] <= write_data;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd
        assign read_data[gi*WIDTH +: WIDTH] = r_mem[w_rd_sel][gi];
    end

    assign valid_o = r_full[w_rd_sel];
    assign fill_o  = FW'(r_wr_idx);
    assign ovf_o   = r_ovf;

`ifdef UART_FRAME_TIMEOUT_EN
    logic r_timeout;

    uart_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .arstn   (arstn),
        .i_clear (push | resync_i),
        .i_enable(r_wr_idx != '0),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_cfg;

    assign w_expire     = 1'b0;
    assign timeout_o    = 1'b0;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
module tb_uart_rx_frame_assembler;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int FW = $clog2(D + 1);

    logic             clk;
    logic             arstn;
    logic             push;
    logic [W-1:0]     write_data;
    logic             resync_i;
    logic             valid_o;
    logic             ready_i;
    logic [D*W-1:0]   read_data;
    logic [FW-1:0]    fill_o;
    logic             ovf_o;
    logic             clr_ovf_i;
    logic             timeout_o;

    logic [D*W-1:0]   exp_q[$];
    int               n_tests;
    int               n_fail;
    int               valid_cnt;
    int               pulses;
    int               first_pulse;

    uart_rx_frame_assembler #(
        .WIDTH(W),
        .DEPTH(D),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .push      (push),
        .write_data(write_data),
        .resync_i  (resync_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .read_data (read_data),
        .fill_o    (fill_o),
        .ovf_o     (ovf_o),
        .clr_ovf_i (clr_ovf_i),
        .timeout_o (timeout_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        push       = 1'b1;
        write_data = d;
        cycle();
        push       = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus, monitor, report ----------------
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        valid_cnt  = 0;
        arstn      = 1'b0;
        push       = 1'b0;
        write_data = '0;
        resync_i   = 1'b0;
        ready_i    = 1'b0;
        clr_ovf_i  = 1'b0;

        // Monitor: pops the scoreboard on every accepted frame.
        fork
            forever begin
                @(negedge clk);
                if (arstn && valid_o) begin
                    valid_cnt++;
                    if (ready_i) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_frame: got %0h expected none", read_data);
                        end else begin
                            check("frame", read_data, exp_q.pop_front());
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #3 arstn = 1'b1;
        cycle();
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_fill", {29'b0, fill_o}, 32'h0);
        check("rst_ovf", {31'b0, ovf_o}, 32'h0);
        check("rst_timeout", {31'b0, timeout_o}, 32'h0);

        // 1: first frame, consumer stalled
        push_word(8'h11); check("fill1", {29'b0, fill_o}, 32'd1);
        push_word(8'h22); check("fill2", {29'b0, fill_o}, 32'd2);
        push_word(8'h33); check("fill3", {29'b0, fill_o}, 32'd3);
        check("valid_before_last", {31'b0, valid_o}, 32'h0);
        push_word(8'h44); check("fill0", {29'b0, fill_o}, 32'd0);
        check("valid_after_last", {31'b0, valid_o}, 32'h1);
        check("word0", {24'b0, read_data[7:0]}, 32'h11);
        check("word3", {24'b0, read_data[31:24]}, 32'h44);

        // 2: second bank fills, rest overflow
        for (int i = 0; i < 8; i++) push_word(8'h55 + 8'(i * 17));
        check("ovf_set", {31'b0, ovf_o}, 32'h1);
        check("fill_after_drop", {29'b0, fill_o}, 32'd0);
        check("hold_stable", read_data, 32'h44332211);
        exp_q.push_back(32'h44332211);
        exp_q.push_back(32'h88776655);
        clr_ovf_i = 1'b1;
        cycle();
        clr_ovf_i = 1'b0;
        check("ovf_clear", {31'b0, ovf_o}, 32'h0);
        // both banks full: read frees a bank but the push still drops
        ready_i = 1'b1;
        push_word(8'hDD);
        check("ovf_read_and_push", {31'b0, ovf_o}, 32'h1);
        check("fill_read_and_push", {29'b0, fill_o}, 32'd0);
        cycle();
        ready_i = 1'b0;
        check("valid_drained", {31'b0, valid_o}, 32'h0);
        clr_ovf_i = 1'b1;
        cycle();
        clr_ovf_i = 1'b0;
        check("ovf_clear2", {31'b0, ovf_o}, 32'h0);

        // 3: resync mid-frame together with a push
        ready_i = 1'b1;
        push_word(8'hA1);
        push_word(8'hA2);
        check("fill_pre_resync", {29'b0, fill_o}, 32'd2);
        resync_i = 1'b1;
        push_word(8'hB0);
        resync_i = 1'b0;
        check("fill_post_resync", {29'b0, fill_o}, 32'd1);
        exp_q.push_back(32'hB3B2B1B0);
        push_word(8'hB1);
        push_word(8'hB2);
        push_word(8'hB3);
        cycle();

        // 4: streaming with ready held high
        valid_cnt = 0;
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        for (int i = 1; i <= 12; i++) push_word(8'(i));
        cycle();
        check("stream_valid_cycles", valid_cnt, 32'd3);
        check("stream_no_ovf", {31'b0, ovf_o}, 32'h0);
        ready_i = 1'b0;

        // 5: reset mid-frame while a frame waits
        push_word(8'hC1); push_word(8'hC2); push_word(8'hC3); push_word(8'hC4);
        push_word(8'hD1); push_word(8'hD2);
        check("pre_rst_valid", {31'b0, valid_o}, 32'h1);
        check("pre_rst_fill", {29'b0, fill_o}, 32'd2);
        arstn = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, valid_o}, 32'h0);
        check("mid_rst_fill", {29'b0, fill_o}, 32'd0);
        check("mid_rst_ovf", {31'b0, ovf_o}, 32'h0);
        cycle();
        arstn = 1'b1;
        cycle();
        ready_i = 1'b1;
        exp_q.push_back(32'hE4E3E2E1);
        push_word(8'hE1); push_word(8'hE2); push_word(8'hE3); push_word(8'hE4);
        cycle();
        ready_i = 1'b0;

        // 6: idle timeout of a partial frame
        push_word(8'hF1);
        check("partial_fill", {29'b0, fill_o}, 32'd1);
        pulses      = 0;
        first_pulse = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
`ifdef UART_FRAME_TIMEOUT_EN
            if (timeout_o) begin
                pulses++;
                if (first_pulse == 0) first_pulse = k;
            end
`else
            check("timeout_low", {31'b0, timeout_o}, 32'h0);
`endif
        end
`ifdef UART_FRAME_TIMEOUT_EN
        check("timeout_pulses", pulses, 32'd1);
        check("timeout_cycle", first_pulse, 32'd16);
        check("timeout_fill", {29'b0, fill_o}, 32'd0);
`else
        check("no_timeout_fill", {29'b0, fill_o}, 32'd1);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
